// File: rtl/rom_seq_ctrl_pkg.sv
// Shared types and sizing for the coefficient ROM read sequencer.
// ROM_LAT counts the issue register plus the ROM output register.
package rom_seq_pkg;

    localparam int DATA_W  = 40;
    localparam int ADDR_W  = 8;
    localparam int DEPTH   = 142;
    localparam int FIFO_D  = 4;
    localparam int ROM_LAT = 2;

    localparam int CNT_W   = ADDR_W + 1;
    localparam int SUM_W   = ADDR_W + 2;
    localparam int OCC_W   = $clog2(FIFO_D + 1);
    localparam int PEND_W  = OCC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } word_t;

    localparam int WORD_W = $bits(word_t);

    // Widened sum so base+count can never wrap before the range test.
    function automatic logic cmd_fits(input logic [ADDR_W-1:0] base,
                                      input logic [CNT_W-1:0]  cnt);
        return (SUM_W'(base) + SUM_W'(cnt)) <= SUM_W'(DEPTH);
    endfunction

endpackage

// File: rtl/rom_seq_ctrl_if.sv
// Command, ROM and output-stream signals of the ROM read sequencer.
// master is the sequencer's view; slave is the ROM/consumer/commander view.
interface rom_seq_ctrl_if;
    import rom_seq_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  count;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] rom_A;
    logic              rom_cen;
    logic [DATA_W-1:0] rom_Q;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        input  start, base_addr, count, rom_Q, out_ready,
        output busy, done, err, rom_A, rom_cen, out_data, out_valid, out_last
    );

    modport slave (
        output start, base_addr, count, rom_Q, out_ready,
        input  busy, done, err, rom_A, rom_cen, out_data, out_valid, out_last
    );

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with occupancy count; rd_dat reads 0 when empty.
// Write and read may coincide on a full FIFO; a write to a full FIFO without a read is illegal.
module sync_fifo #(
    parameter  int W  = 41,
    parameter  int D  = 4,
    localparam int CW = $clog2(D + 1),
    localparam int PW = (D > 1) ? $clog2(D) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    output logic          rd_vld,
    input  logic          rd_rdy,
    output logic [W-1:0]  rd_dat,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [D];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          wr_en, rd_en, full, empty;

    function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty  = (count == '0);
    assign full   = (count == CW'(D));
    assign rd_vld = !empty;
    assign rd_en  = rd_vld && rd_rdy;
    assign wr_en  = wr_vld && (!full || rd_en);
    assign rd_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_nxt(wr_ptr);
            if (rd_en) rd_ptr <= ptr_nxt(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_dat;
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !(wr_vld && full && !rd_en));

endmodule

// File: rtl/rom_seq_ctrl.sv
// Bursts count words from a registered-read ROM into a valid/ready stream.
// First word is valid two edges after the start accept edge; issue throttles so FIFO + in-flight never exceeds FIFO_D.
module rom_seq_ctrl
    import rom_seq_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    rom_seq_ctrl_if.master bus
);

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  addr_q, issue_addr;
    logic [CNT_W-1:0]   iss_rem, out_rem;
    logic [ROM_LAT-1:0] infl, infl_last;
    logic [OCC_W-1:0]   fifo_cnt;
    logic [PEND_W-1:0]  pending;
    word_t              fifo_in, fifo_out;

    logic cmd_zero, cmd_fit, accept, can_issue;
    logic issue_en, issue_last, pop, final_pop;
    logic busy_nx, done_nx, err_nx;

    assign cmd_zero  = (bus.count == '0);
    assign cmd_fit   = cmd_fits(bus.base_addr, bus.count);
    assign accept    = (state == IDLE) && bus.start && !cmd_zero && cmd_fit;
    assign pending   = PEND_W'(fifo_cnt) + PEND_W'($countones(infl));
    assign can_issue = (pending < PEND_W'(FIFO_D));
    assign pop       = bus.out_valid && bus.out_ready;
    assign final_pop = pop && (out_rem == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (bus.count == CNT_W'(1)) ? DRAIN : ISSUE;
            ISSUE:   if (issue_en && iss_rem == CNT_W'(1)) state_nx = DRAIN;
            DRAIN:   if (final_pop) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The accept edge itself issues the first read, which hides one cycle of latency.
    always_comb begin
        issue_en   = 1'b0;
        issue_addr = addr_q;
        issue_last = 1'b0;
        busy_nx    = 1'b0;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (cmd_zero) begin
                        done_nx = 1'b1;
                    end else if (!cmd_fit) begin
                        err_nx = 1'b1;
                    end else begin
                        issue_en   = 1'b1;
                        issue_addr = bus.base_addr;
                        issue_last = (bus.count == CNT_W'(1));
                        busy_nx    = 1'b1;
                    end
                end
            end
            ISSUE: begin
                busy_nx    = 1'b1;
                issue_en   = can_issue;
                issue_last = (iss_rem == CNT_W'(1));
            end
            DRAIN: begin
                busy_nx = !final_pop;
                done_nx = final_pop;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rom_cen <= 1'b0;
            bus.rom_A   <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
            addr_q      <= '0;
            iss_rem     <= '0;
            out_rem     <= '0;
            infl        <= '0;
            infl_last   <= '0;
        end else begin
            bus.rom_cen <= issue_en;
            if (issue_en) begin
                bus.rom_A <= issue_addr;
                addr_q    <= issue_addr + ADDR_W'(1);
            end
            if (accept)        iss_rem <= bus.count - CNT_W'(1);
            else if (issue_en) iss_rem <= iss_rem - CNT_W'(1);
            if (accept)        out_rem <= bus.count;
            else if (pop)      out_rem <= out_rem - CNT_W'(1);
            // Only tracked returns are captured; rom_Q is never trusted while cen was low.
            infl        <= {infl[ROM_LAT-2:0], issue_en};
            infl_last   <= {infl_last[ROM_LAT-2:0], issue_en && issue_last};
            bus.busy    <= busy_nx;
            bus.done    <= done_nx;
            bus.err     <= err_nx;
        end
    end

    assign fifo_in.last = infl_last[ROM_LAT-1];
    assign fifo_in.data = bus.rom_Q;

    sync_fifo #(
        .W (WORD_W),
        .D (FIFO_D)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (infl[ROM_LAT-1]),
        .wr_dat (fifo_in),
        .rd_vld (bus.out_valid),
        .rd_rdy (bus.out_ready),
        .rd_dat (fifo_out),
        .count  (fifo_cnt)
    );

    assign bus.out_data = fifo_out.data;
    assign bus.out_last = fifo_out.last;

endmodule
